cpu_operand_fetch: RTL and testbench
====================================

Name: cpu_operand_fetch

Overview:
Operand-fetch stage that sits in front of the 16x32 byte-enabled CPU register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file's two asynchronous read addresses.
- Merges same-cycle writeback bytes into the operands (bypass) and registers the operands toward execute.
- A per-register pending scoreboard stalls any instruction that reads or overwrites a register whose producer has not yet committed.

Parameters:
DW, 32, data width; fixed at 4 byte lanes
AW, 4, register address width; 2**AW = 16 registers

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  decoded instruction valid
in_ready_o  output  1  stage accepts instruction this cycle
in_rs0_i  input  AW  source register 0
in_rs1_i  input  AW  source register 1
in_rd_i  input  AW  destination register
in_rd_we_i  input  1  instruction writes in_rd_i
rf_rd0_addr_o  output  AW  register file read address 0
rf_rd1_addr_o  output  AW  register file read address 1
rf_rd0_data_i  input  DW  register file read data 0 (asynchronous)
rf_rd1_data_i  input  DW  register file read data 1 (asynchronous)
wb_addr_i  input  AW  register file write address (tapped copy)
wb_byte_en_i  input  4  register file byte enables (tapped copy)
wb_data_i  input  DW  register file write data (tapped copy)
wb_commit_i  input  1  this write is the producer's final write; clears pending
out_valid_o  output  1  operands valid
out_ready_i  input  1  execute consumes operands
out_op0_o  output  DW  operand 0
out_op1_o  output  DW  operand 1
out_rd_o  output  AW  destination register
out_rd_we_o  output  1  destination write flag
stall_cnt_o  output  16  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid_o=0, out_op0_o=0, out_op1_o=0, out_rd_o=0, out_rd_we_o=0, stall_cnt_o=0, all 16 pending bits=0, state=EMPTY.
- Read addresses: rf_rd0_addr_o=in_rs0_i and rf_rd1_addr_o=in_rs1_i, combinational and unconditional.
- Bypass, per byte lane k, for each operand:
  - If wb_byte_en_i[k]=1 and wb_addr_i equals the source, take wb_data_i[8k+7:8k].
  - Otherwise take the register-file byte.
  - This covers the register file's write-then-read-next-cycle timing.
- clr[r] = wb_commit_i and wb_byte_en_i!=0 and wb_addr_i==r.
- Hazard, when in_valid_i=1: any of rs0, rs1, or rd (only if in_rd_we_i=1) has pending=1 and clr=0 for that register. A same-cycle commit resolves the hazard and the byte bypass supplies the data.
- Slot free: out_valid_o=0 or out_ready_i=1.
- in_ready_o = slot free and no hazard. It is independent of in_valid_i except through the hazard term.
- Accept: in_valid_i and in_ready_o. On accept, the bypassed operands, rd and rd_we load into the output registers and out_valid_o=1 next cycle. Latency is 1 cycle.
- Pending update: on accept with in_rd_we_i=1, pending[in_rd_i] is set. clr clears pending[r]. If set and clear hit the same register in the same cycle, set wins.
- Output hold: outputs hold stable while out_valid_o=1 and out_ready_i=0. When out_ready_i=1 and there is no accept, out_valid_o=0 next cycle.
- State machine (state is observable via out_valid_o plus the hazard condition):
  - EMPTY: out_valid_o=0.
  - FULL: out_valid_o=1, no hazard.
  - STALL: in_valid_i=1 and hazard.
  - Transitions: EMPTY to FULL on accept. FULL to FULL on consume plus accept. FULL to EMPTY on consume with no accept. Any state to STALL on hazard. STALL to FULL or EMPTY once the hazard clears.
- stall_cnt_o increments by 1 per cycle that in_valid_i=1 and hazard=1. It saturates at 16'hFFFF.
- Reset mid-operation: the in-flight output is discarded, the scoreboard clears, and the counter clears.

Optional Feature:
Macro: CPU_OPF_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 32'h0 on both operands, regardless of register-file data or bypass.
  - An accept with in_rd_i=0 never sets pending[0], and register 0 never causes a hazard.
  - out_rd_we_o is forced to 0 when in_rd_i=0.
- Undefined: register 0 is an ordinary register, with the same read, bypass and scoreboard rules as registers 1 to 15.

Test Plan:
1. Plain fetch: r3=32'h11223344, r5=32'hA5A5A5A5 preloaded. Issue rs0=3, rs1=5, rd=7, rd_we=1 with out_ready_i=1 -> next cycle out_op0_o=32'h11223344, out_op1_o=32'hA5A5A5A5, out_rd_o=7, pending[7]=1.
2. Byte bypass: r3=32'h11223344. In the fetch cycle drive wb_addr_i=3, wb_byte_en_i=4'b0101, wb_data_i=32'hDEADBEEF -> out_op0_o=32'h11AD33EF.
3. RAW stall: pending[7]=1, issue rs1=7 -> in_ready_o=0 and stall_cnt_o counts 1, 2, 3. Then wb_commit_i=1, wb_addr_i=7, wb_byte_en_i=4'hF, wb_data_i=32'h0000CAFE -> accepted that cycle, out_op1_o=32'h0000CAFE, pending[7]=0.
4. Backpressure: out_ready_i=0 for 4 cycles with a second instruction waiting -> outputs stay constant and in_ready_o=0. Release out_ready_i -> the second instruction loads in the same cycle with no bubble.
5. Set/clear collision: accept rd=9 with rd_we=1 while committing r9 in the same cycle -> pending[9]=1 afterwards.
6. Reset mid-stall: assert rst_n=0 asynchronously mid-cycle -> out_valid_o=0, stall_cnt_o=0 and all pending bits 0 immediately. With CPU_OPF_ZERO_REG_EN defined, rs0=0 -> out_op0_o=32'h0.

Source files
------------

// File: rtl/cpu_operand_fetch.sv
// cpu_operand_fetch
//   Operand-fetch stage in front of the 16x32 byte-enabled register file.
//   Drives the two asynchronous read ports, merges same-cycle writeback
//   bytes into the operands, and registers them toward execute behind a
//   valid/ready handshake. A pending-write scoreboard holds back any
//   instruction that touches a register whose producer has not committed.
//
//   Optional build macro: CPU_OPF_ZERO_REG_EN
//     When defined, register 0 is hardwired to zero. It reads as zero,
//     never goes pending, never stalls, and never reports a write.
module cpu_operand_fetch #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] in_rs0_i,
    input  logic [AW-1:0] in_rs1_i,
    input  logic [AW-1:0] in_rd_i,
    input  logic          in_rd_we_i,
    output logic [AW-1:0] rf_rd0_addr_o,
    output logic [AW-1:0] rf_rd1_addr_o,
    input  logic [DW-1:0] rf_rd0_data_i,
    input  logic [DW-1:0] rf_rd1_data_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [3:0]    wb_byte_en_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          wb_commit_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_op0_o,
    output logic [DW-1:0] out_op1_o,
    output logic [AW-1:0] out_rd_o,
    output logic          out_rd_we_o,
    output logic [15:0]   stall_cnt_o
);

    localparam int NREG  = 1 << AW;
    localparam int NLANE = DW / 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Merge the tapped writeback bytes over the register-file word. The
    // register file only shows a write on the following cycle, so any lane
    // being written right now must come from the writeback bus instead.
    function automatic logic [DW-1:0] bypass(
        input logic [AW-1:0] src,
        input logic [DW-1:0] rf_word,
        input logic [AW-1:0] wb_addr,
        input logic [3:0]    wb_be,
        input logic [DW-1:0] wb_data
    );
        logic [DW-1:0] word;
        word = rf_word;
        for (int k = 0; k < NLANE; k++) begin
            if (wb_be[k] && (wb_addr == src)) begin
                word[8*k +: 8] = wb_data[8*k +: 8];
            end
        end
`ifdef CPU_OPF_ZERO_REG_EN
        if (src == '0) begin
            word = '0;
        end
`endif
        return word;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    state_t          state;
    state_t          state_next;
    logic            held_p1;
    logic            valid_next;

    logic [NREG-1:0] pending_p1;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] blocked;

    logic            hazard;
    logic            slot_free;
    logic            accept;
    logic            rd_we_p0;
    logic [DW-1:0]   op0_p0;
    logic [DW-1:0]   op1_p0;

    logic [DW-1:0]   op0_p1;
    logic [DW-1:0]   op1_p1;
    logic [AW-1:0]   rd_p1;
    logic            rd_we_p1;
    logic [15:0]     stall_cnt_p1;

    // ---- p0: decode-side operand fetch and hazard detection ----

    // Read addresses follow the incoming sources with no qualification.
    always_comb begin
        rf_rd0_addr_o = in_rs0_i;
        rf_rd1_addr_o = in_rs1_i;
    end

    // Bypassed operands and the effective destination write flag.
    always_comb begin
        op0_p0   = bypass(in_rs0_i, rf_rd0_data_i, wb_addr_i, wb_byte_en_i, wb_data_i);
        op1_p0   = bypass(in_rs1_i, rf_rd1_data_i, wb_addr_i, wb_byte_en_i, wb_data_i);
        rd_we_p0 = in_rd_we_i;
`ifdef CPU_OPF_ZERO_REG_EN
        if (in_rd_i == '0) begin
            rd_we_p0 = 1'b0;
        end
`endif
    end

    // A committing write with at least one byte lane retires its register.
    always_comb begin
        clr = '0;
        for (int r = 0; r < NREG; r++) begin
            clr[r] = wb_commit_i && (wb_byte_en_i != 4'd0) && (wb_addr_i == AW'(r));
        end
    end

    // Registers still owned by an in-flight producer; a same-cycle commit
    // releases its register because the bypass already supplies the data.
    always_comb begin
        blocked = pending_p1 & ~clr;
`ifdef CPU_OPF_ZERO_REG_EN
        blocked[0] = 1'b0;
`endif
        hazard = in_valid_i &&
                 (blocked[in_rs0_i] || blocked[in_rs1_i] ||
                  (in_rd_we_i && blocked[in_rd_i]));
    end

    // Scoreboard update: a new producer's set takes priority over a clear.
    always_comb begin
        pending_next = pending_p1 & ~clr;
        if (accept && rd_we_p0) begin
            pending_next[in_rd_i] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_p1 <= '0;
        end else begin
            pending_p1 <= pending_next;
        end
    end

    // ---- Handshake state machine ----

    // State register; held_p1 records output occupancy while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            held_p1 <= 1'b0;
        end else begin
            state   <= state_next;
            held_p1 <= valid_next;
        end
    end

    // Next state: a waiting hazard dominates, otherwise occupancy decides.
    always_comb begin
        valid_next = accept || (out_valid_o && !out_ready_i);
        if (hazard) begin
            state_next = STALL;
        end else if (valid_next) begin
            state_next = FULL;
        end else begin
            state_next = EMPTY;
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        out_valid_o = (state == FULL) || ((state == STALL) && held_p1);
        slot_free   = !out_valid_o || out_ready_i;
        in_ready_o  = slot_free && !hazard;
        accept      = in_valid_i && in_ready_o;
    end

    // ---- p1: operand registers toward execute ----

    // Load on accept; otherwise hold, including across backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op0_p1   <= '0;
            op1_p1   <= '0;
            rd_p1    <= '0;
            rd_we_p1 <= 1'b0;
        end else if (accept) begin
            op0_p1   <= op0_p0;
            op1_p1   <= op1_p0;
            rd_p1    <= in_rd_i;
            rd_we_p1 <= rd_we_p0;
        end
    end

    // Count every cycle an instruction is held back by the scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (hazard) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    // Registered outputs.
    always_comb begin
        out_op0_o   = op0_p1;
        out_op1_o   = op1_p1;
        out_rd_o    = rd_p1;
        out_rd_we_o = rd_we_p1;
        stall_cnt_o = stall_cnt_p1;
    end

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Bench for cpu_operand_fetch: register-file memory, a behavioural model of
// the stage, a per-cycle compare process and directed literal checks.
module tb_cpu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs0, in_rs1, in_rd;
    logic        in_rd_we;
    logic [3:0]  rf_rd0_addr, rf_rd1_addr;
    logic [31:0] rf_rd0_data, rf_rd1_data;
    logic [3:0]  wb_addr;
    logic [3:0]  wb_byte_en;
    logic [31:0] wb_data;
    logic        wb_commit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op0, out_op1;
    logic [3:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [31:0] rf [16];

    cpu_operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs0_i(in_rs0), .in_rs1_i(in_rs1), .in_rd_i(in_rd), .in_rd_we_i(in_rd_we),
        .rf_rd0_addr_o(rf_rd0_addr), .rf_rd1_addr_o(rf_rd1_addr),
        .rf_rd0_data_i(rf_rd0_data), .rf_rd1_data_i(rf_rd1_data),
        .wb_addr_i(wb_addr), .wb_byte_en_i(wb_byte_en), .wb_data_i(wb_data),
        .wb_commit_i(wb_commit),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_op0_o(out_op0), .out_op1_o(out_op1),
        .out_rd_o(out_rd), .out_rd_we_o(out_rd_we),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file: asynchronous read, byte-enabled write on the clock.
    assign rf_rd0_data = rf[rf_rd0_addr];
    assign rf_rd1_data = rf[rf_rd1_addr];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (wb_byte_en[k]) rf[wb_addr][8*k +: 8] <= wb_data[8*k +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 0;
    logic [31:0] m_op0 = 0, m_op1 = 0;
    logic [3:0]  m_rd = 0;
    logic        m_rd_we = 0;
    logic [15:0] m_pend = 0;
    logic [15:0] m_cnt = 0;

    logic        n_valid = 0;
    logic [31:0] n_op0 = 0, n_op1 = 0;
    logic [3:0]  n_rd = 0;
    logic        n_rd_we = 0;
    logic [15:0] n_pend = 0;
    logic [15:0] n_cnt = 0;

    bit haz, exp_ready, acc, we_eff;

    function automatic logic [31:0] fetch(input logic [3:0] rs);
        logic [31:0] v;
        v = rf[rs];
        for (int k = 0; k < 4; k++)
            if (wb_byte_en[k] && wb_addr == rs) v[8*k +: 8] = wb_data[8*k +: 8];
`ifdef CPU_OPF_ZERO_REG_EN
        if (rs == 0) v = 32'h0;
`endif
        return v;
    endfunction

    function automatic bit busy(input logic [3:0] r);
        bit b;
        b = m_pend[r] && !(wb_commit && wb_byte_en != 0 && wb_addr == r);
`ifdef CPU_OPF_ZERO_REG_EN
        if (r == 0) b = 0;
`endif
        return b;
    endfunction

    // Compare DUT against the model, then work out the model's next state.
    always @(negedge clk) begin
        haz       = in_valid && (busy(in_rs0) || busy(in_rs1) || (in_rd_we && busy(in_rd)));
        exp_ready = (!m_valid || out_ready) && !haz;
        acc       = in_valid && exp_ready;
        we_eff    = in_rd_we;
`ifdef CPU_OPF_ZERO_REG_EN
        if (in_rd == 0) we_eff = 0;
`endif
        if (chk_en) begin
            check("m_in_ready", in_ready, exp_ready);
            check("m_out_valid", out_valid, m_valid);
            check("m_stall_cnt", stall_cnt, m_cnt);
            check("m_rd0_addr", rf_rd0_addr, in_rs0);
            check("m_rd1_addr", rf_rd1_addr, in_rs1);
            if (m_valid) begin
                check("m_op0", out_op0, m_op0);
                check("m_op1", out_op1, m_op1);
                check("m_rd", out_rd, m_rd);
                check("m_rd_we", out_rd_we, m_rd_we);
            end
        end
        n_valid = m_valid; n_op0 = m_op0; n_op1 = m_op1; n_rd = m_rd; n_rd_we = m_rd_we;
        if (acc) begin
            n_valid = 1; n_op0 = fetch(in_rs0); n_op1 = fetch(in_rs1);
            n_rd = in_rd; n_rd_we = we_eff;
        end else if (out_ready) begin
            n_valid = 0;
        end
        n_pend = m_pend;
        for (int r = 0; r < 16; r++)
            if (wb_commit && wb_byte_en != 0 && wb_addr == r) n_pend[r] = 0;
        if (acc && we_eff) n_pend[in_rd] = 1;
        n_cnt = m_cnt;
        if (haz && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_op0 <= 0; m_op1 <= 0; m_rd <= 0; m_rd_we <= 0;
            m_pend <= 0; m_cnt <= 0;
        end else begin
            m_valid <= n_valid; m_op0 <= n_op0; m_op1 <= n_op1; m_rd <= n_rd;
            m_rd_we <= n_rd_we; m_pend <= n_pend; m_cnt <= n_cnt;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_rs0 = 0; in_rs1 = 0; in_rd = 0; in_rd_we = 0;
        wb_addr = 0; wb_byte_en = 0; wb_data = 0; wb_commit = 0;
    endtask

    task automatic issue(input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [3:0] rd, input logic we);
        in_valid = 1; in_rs0 = rs0; in_rs1 = rs1; in_rd = rd; in_rd_we = we;
    endtask

    task automatic wb(input logic [3:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic c);
        wb_addr = a; wb_byte_en = be; wb_data = d; wb_commit = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        out_ready = 1;
        rst_n = 0;
        for (int i = 0; i < 16; i++) rf[i] <= 32'h01010101 * i;
        rf[0] <= 32'h0BADF00D;
        rf[3] <= 32'h11223344;
        rf[5] <= 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_op0", out_op0, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1;
        chk_en = 1;

        // Plain fetch
        issue(3, 5, 7, 1);
        at_neg(); check("t1_ready", in_ready, 1);
        tick(); idle();
        at_neg();
        check("t1_op0", out_op0, 32'h11223344);
        check("t1_op1", out_op1, 32'hA5A5A5A5);
        check("t1_rd", out_rd, 7);
        check("t1_valid", out_valid, 1);

        // Byte bypass
        tick(); issue(3, 5, 2, 0); wb(3, 4'b0101, 32'hDEADBEEF, 0);
        at_neg(); tick(); idle();
        at_neg(); check("t2_op0", out_op0, 32'h11AD33EF);

        // RAW stall on r7, then resolved by a same-cycle commit
        tick(); issue(1, 7, 4, 0);
        at_neg(); check("t3_ready", in_ready, 0); check("t3_cnt0", stall_cnt, 0);
        tick(); at_neg(); check("t3_cnt1", stall_cnt, 1);
        tick(); at_neg(); check("t3_cnt2", stall_cnt, 2);
        tick(); wb(7, 4'hF, 32'h0000CAFE, 1);
        at_neg(); check("t3_cnt3", stall_cnt, 3); check("t3_commit_ready", in_ready, 1);
        tick(); idle();
        at_neg(); check("t3_op1", out_op1, 32'h0000CAFE); check("t3_cnt_hold", stall_cnt, 3);
        tick(); issue(7, 7, 0, 0);
        at_neg(); check("t3_r7_free", in_ready, 1);

        // Backpressure with a second instruction waiting
        tick(); out_ready = 0; issue(5, 3, 8, 1);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("t4_ready_low", in_ready, 0);
            check("t4_hold_op0", out_op0, 32'h0000CAFE);
            check("t4_hold_valid", out_valid, 1);
            tick();
        end
        out_ready = 1;
        at_neg(); check("t4_release_ready", in_ready, 1);
        tick(); idle();
        at_neg();
        check("t4_op0", out_op0, 32'hA5A5A5A5);
        check("t4_op1", out_op1, 32'h11AD33EF);
        check("t4_rd", out_rd, 8);
        check("t4_valid", out_valid, 1);

        // Commit with no byte enables must not clear pending[8]
        tick(); issue(8, 0, 0, 0); wb(8, 4'h0, 32'hFFFFFFFF, 1);
        at_neg(); check("nobe_ready", in_ready, 0);
        tick(); wb(8, 4'hF, 32'h13572468, 1);
        at_neg(); check("be_ready", in_ready, 1);
        tick(); idle();
        at_neg(); check("be_op0", out_op0, 32'h13572468);

        // Set/clear collision on r9
        tick(); issue(0, 0, 9, 1);
        at_neg(); check("t5_first_ready", in_ready, 1);
        tick(); issue(1, 2, 9, 1); wb(9, 4'hF, 32'h12345678, 1);
        at_neg(); check("t5_collide_ready", in_ready, 1);
        tick(); idle(); issue(9, 1, 0, 0);
        at_neg(); check("t5_set_wins", in_ready, 0);
        tick(); wb(9, 4'b0001, 32'h000000AA, 1);
        at_neg(); check("t5_clear_ready", in_ready, 1);
        tick(); idle();
        at_neg(); check("t5_op0", out_op0, 32'h123456AA); check("t5_op1", out_op1, 32'h01010101);

        // Asynchronous reset in the middle of a stall
        tick(); issue(0, 0, 10, 1);
        tick(); issue(10, 0, 0, 0);
        at_neg(); check("t6_stall", in_ready, 0);
        tick(); tick();
        #2 rst_n = 0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_cnt", stall_cnt, 0);
        check("t6_rst_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        at_neg(); check("t6_after_ready", in_ready, 1);
        tick(); idle();
        at_neg(); check("t6_op0", out_op0, 32'h0A0A0A0A); check("t6_valid", out_valid, 1);

`ifdef CPU_OPF_ZERO_REG_EN
        tick(); issue(0, 0, 0, 1); wb(0, 4'hF, 32'hFFFFFFFF, 1);
        at_neg(); check("z_ready", in_ready, 1);
        tick(); idle();
        at_neg();
        check("z_op0", out_op0, 32'h0);
        check("z_op1", out_op1, 32'h0);
        check("z_rd_we", out_rd_we, 0);
        tick(); issue(0, 0, 0, 0);
        at_neg(); check("z_no_pend", in_ready, 1);
        tick(); idle();
`else
        tick(); issue(0, 0, 11, 0);
        at_neg(); tick(); idle();
        at_neg(); check("r0_plain", out_op0, 32'h0BADF00D);
`endif

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
